// File: rtl/serial_adder_ctrl.sv
// Sequencer for the 1-bit Mealy serial adder: loads two parallel operands, streams them
// LSB-first with one flush cycle for the final carry, and gathers the WIDTH+1-bit sum.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ser_x,
    output logic             ser_y,
    input  logic             ser_s,
    output logic             adder_clr,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] xsh;
    logic [WIDTH-1:0] ysh;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, bit counter and result collector; sum holds outside RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            xsh <= '0;
            ysh <= '0;
            cnt <= '0;
            sum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xsh <= a;
                        ysh <= b;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sum <= {ser_s, sum[WIDTH:1]};
                    xsh <= {1'b0, xsh[WIDTH-1:1]};
                    ysh <= {1'b0, ysh[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Once the operands are shifted out, xsh/ysh read 0, giving the flush cycle x=y=0.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ser_x     = 1'b0;
        ser_y     = 1'b0;
        adder_clr = 1'b1;
        case (state)
            RUN: begin
                busy      = 1'b1;
                adder_clr = 1'b0;
                ser_x     = xsh[0];
                ser_y     = ysh[0];
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a behavioural serial adder closes the loop, and results are
// checked against plain a+b arithmetic held in an expected queue.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
    logic         ser_x;
    logic         ser_y;
    logic         ser_s;
    logic         adder_clr;
    logic [1:0]   state_dbg;

    logic         carry;
    logic [W:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .sum(sum),
        .ser_x(ser_x),
        .ser_y(ser_y),
        .ser_s(ser_s),
        .adder_clr(adder_clr),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Mealy serial adder with synchronous carry clear
    always @(posedge clock) begin
        if (adder_clr) carry <= 1'b0;
        else           carry <= (ser_x & ser_y) | (ser_x & carry) | (ser_y & carry);
    end
    assign ser_s = ser_x ^ ser_y ^ carry;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding a+b
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_done", {31'd0, done}, 32'd0);
            else                   check("sum", {23'd0, sum}, {23'd0, exp_q.pop_front()});
        end
    end

    // One full operation; noisy=1 toggles start and operands while the op is in flight.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input bit noisy);
        logic [W:0] exp_sum;
        exp_sum = {1'b0, op_a} + {1'b0, op_b};
        @(negedge clock);
        start = 1'b1;
        a = op_a;
        b = op_b;
        exp_q.push_back(exp_sum);
        @(posedge clock);
        for (int k = 0; k <= W; k++) begin
            @(negedge clock);
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_done", {31'd0, done}, 32'd0);
            check("run_clr", {31'd0, adder_clr}, 32'd0);
            check("ser_x", {31'd0, ser_x}, ({24'd0, op_a} >> k) & 32'd1);
            check("ser_y", {31'd0, ser_y}, ({24'd0, op_b} >> k) & 32'd1);
            @(posedge clock);
        end
        @(negedge clock);
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_clr", {31'd0, adder_clr}, 32'd1);
        check("done_ser_x", {31'd0, ser_x}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("sum_held", {23'd0, sum}, {23'd0, exp_sum});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sum"}, {23'd0, sum}, 32'd0);
        check({tag, "_ser"}, {30'd0, ser_x, ser_y}, 32'd0);
        check({tag, "_clr"}, {31'd0, adder_clr}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_reset_state("reset");

        // Directed operands
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hDC, 8'hBA, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b0);

        // Randomized operands, half with start/operand noise during RUN
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), i[0]);
        end

        // start held high with fresh operands every cycle
        @(negedge clock);
        start = 1'b1;
        for (int c = 0; c < 44; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (c % 11 == 0) exp_q.push_back({1'b0, a} + {1'b0, b});
            @(posedge clock);
            @(negedge clock);
            check("b2b_busy", {31'd0, busy}, {31'd0, (c % 11) != 10});
            check("b2b_done", {31'd0, done}, {31'd0, (c % 11) == 9});
        end
        start = 1'b0;

        // Reset during RUN cycle 4 discards the operation
        @(negedge clock);
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("abort_in_run", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_reset_state("abort");
        run_op(8'h01, 8'h02, 1'b0);

        // reset and start together: reset wins
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check_reset_state("rst_start");
        @(posedge clock);
        @(negedge clock);
        check("rst_start_stay", {31'd0, busy}, 32'd0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer for the team's 1-bit Mealy serial adder (carry-state FSM, sum output combinational in x, y and carry). It accepts two parallel WIDTH-bit operands on a start request and streams them LSB-first into the adder. It runs one extra flush cycle so the final carry lands in the sum MSB, collects the serial sum bits into a parallel WIDTH+1-bit result, and signals completion. It sits between the parallel-word datapath and the serial adder instance, which it also clears between operations.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2)

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH+1  result register; bit WIDTH is final carry
- ser_x  output  1  serial bit of A to adder x
- ser_y  output  1  serial bit of B to adder y
- ser_s  input  1  adder sum output s (combinational in ser_x, ser_y, adder carry)
- adder_clr  output  1  active-high synchronous clear of adder carry state

## Operation
- Internal state:
  - FSM states IDLE, RUN, DONE
  - shift registers xsh and ysh, WIDTH bits each
  - result shift register, WIDTH+1 bits, drives sum
  - bit counter, covering 0..WIDTH
- Reset values: state IDLE, busy 0, done 0, sum 0, ser_x 0, ser_y 0, adder_clr 1, counter 0, xsh/ysh 0.
- IDLE:
  - Outputs: adder_clr=1, ser_x=ser_y=0.
  - start=1 at an edge: xsh←a, ysh←b, counter←0, go RUN.
  - start=0: stay in IDLE.
- RUN:
  - Outputs: adder_clr=0, ser_x=xsh[0], ser_y=ysh[0].
  - Each edge:
    - sum ← {ser_s, sum[WIDTH:1]} (right shift, new bit enters MSB)
    - xsh, ysh shift right with 0 fill
    - counter+1
  - The edge at counter==WIDTH captures the flush bit (x=y=0, so s = carry) and goes to DONE.
  - RUN lasts exactly WIDTH+1 cycles.
  - After the last shift, sum holds a+b with the carry in bit WIDTH.
- DONE:
  - Outputs: done=1, adder_clr=1, ser_x=ser_y=0.
  - Next edge unconditionally returns to IDLE.
- start is ignored in RUN and DONE; it is neither queued nor buffered.
- sum holds its value from DONE until the first RUN edge of the next operation.
- a and b are sampled only at the accepting edge. Later changes have no effect on the operation in flight.
- Arithmetic is unsigned, modulo 2^(WIDTH+1). Overflow is impossible.

## Timing
- Edge E0 accepts start. RUN cycles are E0→E0+1 … E0+WIDTH→E0+WIDTH+1. Bit k is presented during RUN cycle k and captured at edge E0+k+1.
- done is high for exactly the cycle following edge E0+WIDTH+1. Latency from the accepting edge to done is WIDTH+1 edges; for WIDTH=8 it is 9.
- busy rises after E0 and falls after edge E0+WIDTH+2.
- Back-to-back: if start is held high, the next accept happens at the first IDLE edge, E0+WIDTH+3. Throughput is one operation per WIDTH+3 cycles.
- The adder carry is cleared at E0, because adder_clr=1 throughout IDLE. Carry is 0 during RUN cycle 0.
- Reset mid-RUN or in DONE: at the next edge the block returns to IDLE with all outputs at reset values. sum clears to 0, done is not asserted, and the partial result is discarded. adder_clr=1 in the following cycle.
- reset and start high on the same edge: reset wins and the start is dropped.

## Test plan
Bench: WIDTH=8, serial adder instantiated with its clear driven by adder_clr.
- a=0x00, b=0x00 → ser_x/ser_y 0 for all 9 RUN cycles; done after 9 edges; sum=0x000.
- a=0xDC, b=0xBA → ser_x LSB-first 0,0,1,1,1,0,1,1,0 and ser_y 0,1,0,1,1,1,0,1,0; sum=0x196; done exactly one cycle.
- a=0xFF, b=0x01 → carry ripples through all bits; sum=0x100. Then a=0xA5, b=0x5A → sum=0x0FF, confirming the carry was cleared between operations.
- start held high continuously with changing a/b → accepts only at IDLE edges, spaced 11 cycles apart. Pulsing start during RUN/DONE has no effect. Results correspond to operands present at each accepting edge.
- reset asserted at RUN cycle 4 of a=0xFF, b=0xFF → next cycle: IDLE, busy 0, sum 0, no done pulse. A new start with a=0x01, b=0x02 then gives sum=0x003.
- reset and start high on the same edge → remains IDLE, busy 0.
